// File: rtl/shift_sequencer.sv
// -----------------------------------------------------------------------------
// shift_sequencer
//
// Sequential controller for the ALU's 6-bit shift operation. A request
// (direction, operand, amount) is accepted through a start/ready handshake
// and executed one bit position per clock. A single 1-bit shift stage is
// shared across all amounts. The result is held for the display path, and
// o_done pulses for one cycle when the result becomes final.
//
// Optional feature macro: SHIFT_ROTATE_EN
//   When defined, the i_rotate port exists and is latched on accept.
//   With i_rotate=1 the bit shifted out re-enters at the vacated end.
//   When undefined, all operations are logical shifts with zero fill.
//
// Ports
//   i_clk            system clock, all state updates on the rising edge
//   i_reset          synchronous, active-high reset
//   i_start          request strobe, accepted only while o_ready=1
//   i_to_right       direction: 1 = shift right, 0 = shift left
//   i_operand[5:0]   value to shift
//   i_shamt[2:0]     shift amount, 0..7
//   i_rotate         (SHIFT_ROTATE_EN only) 1 = rotate, 0 = logical shift
//   o_ready          high when a start will be accepted (state != SHIFT)
//   o_busy           high while shifting (state == SHIFT)
//   o_done           one-cycle pulse when the result becomes final
//   o_result_valid   high from completion until the next accept or reset
//   o_result[5:0]    shift register contents, final when o_result_valid=1
//   o_remaining[2:0] shifts still to perform
// -----------------------------------------------------------------------------
module shift_sequencer (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic       i_to_right,
  input  logic [5:0] i_operand,
  input  logic [2:0] i_shamt,
`ifdef SHIFT_ROTATE_EN
  input  logic       i_rotate,
`endif
  output logic       o_ready,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_result_valid,
  output logic [5:0] o_result,
  output logic [2:0] o_remaining
);

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [1:0] r_state;
  logic [5:0] r_result;
  logic [2:0] r_remaining;
  logic       r_to_right;
  logic       r_result_valid;
`ifdef SHIFT_ROTATE_EN
  logic       r_rotate;
`endif

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic       w_accept;
  logic       w_fill_left;
  logic       w_fill_right;
  logic [5:0] w_shifted;
  logic       w_last_step;

  // A request is taken in IDLE or DONE; SHIFT ignores start entirely.
  assign w_accept    = i_start && (r_state != ST_SHIFT);
  assign w_last_step = (r_remaining == 3'd1);

  // Vacated-bit fill: the bit leaving the opposite end in rotate mode,
  // zero in logical mode.
`ifdef SHIFT_ROTATE_EN
  assign w_fill_left  = r_rotate & r_result[5];
  assign w_fill_right = r_rotate & r_result[0];
`else
  assign w_fill_left  = 1'b0;
  assign w_fill_right = 1'b0;
`endif

  // The single shared 1-bit shift stage.
  always_comb begin
    w_shifted = r_result;
    if (r_to_right) begin
      w_shifted = {w_fill_right, r_result[5:1]};
    end else begin
      w_shifted = {r_result[4:0], w_fill_left};
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  // o_result_valid is raised on the edge that enters DONE so that it is
  // already high alongside the done pulse; an accept that leads straight to
  // SHIFT clears it, while an accept with amount 0 completes immediately.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= ST_IDLE;
      r_result       <= '0;
      r_remaining    <= '0;
      r_to_right     <= 1'b0;
      r_result_valid <= 1'b0;
`ifdef SHIFT_ROTATE_EN
      r_rotate       <= 1'b0;
`endif
    end else if (w_accept) begin
      r_result    <= i_operand;
      r_remaining <= i_shamt;
      r_to_right  <= i_to_right;
`ifdef SHIFT_ROTATE_EN
      r_rotate    <= i_rotate;
`endif
      if (i_shamt == 3'd0) begin
        r_state        <= ST_DONE;
        r_result_valid <= 1'b1;
      end else begin
        r_state        <= ST_SHIFT;
        r_result_valid <= 1'b0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Result and valid flag hold indefinitely.
          r_state <= ST_IDLE;
        end
        ST_SHIFT: begin
          r_result    <= w_shifted;
          r_remaining <= r_remaining - 3'd1;
          if (w_last_step) begin
            r_state        <= ST_DONE;
            r_result_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_ready        = (r_state != ST_SHIFT);
  assign o_busy         = (r_state == ST_SHIFT);
  assign o_done         = (r_state == ST_DONE);
  assign o_result_valid = r_result_valid;
  assign o_result       = r_result;
  assign o_remaining    = r_remaining;

endmodule

// File: tb/tb_shift_sequencer.sv
// -----------------------------------------------------------------------------
// tb_shift_sequencer
//
// Self-checking bench for shift_sequencer. Table of directed vectors, hand
// sequences for the multi-cycle corners (ignored start, back-to-back,
// reset abort) and randomized requests against an arithmetic reference.
// Build with +define+SHIFT_ROTATE_EN to also cover rotate mode.
// -----------------------------------------------------------------------------
module tb_shift_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic       to_right;
  logic [5:0] operand;
  logic [2:0] shamt;
  logic       rot;
  logic       ready;
  logic       busy;
  logic       done;
  logic       result_valid;
  logic [5:0] result;
  logic [2:0] remaining;

  int n_checks;
  int n_pass;

  shift_sequencer dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_start        (start),
    .i_to_right     (to_right),
    .i_operand      (operand),
    .i_shamt        (shamt),
`ifdef SHIFT_ROTATE_EN
    .i_rotate       (rot),
`endif
    .o_ready        (ready),
    .o_busy         (busy),
    .o_done         (done),
    .o_result_valid (result_valid),
    .o_result       (result),
    .o_remaining    (remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       dir;
    logic [5:0] op;
    logic [2:0] amt;
    logic       rt;
    logic [5:0] exp;
  } vec_t;

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference: final value from plain arithmetic on the whole operand.
  function automatic logic [5:0] model(input logic dir, input logic [5:0] op,
                                       input logic [2:0] amt, input logic rt);
    int v;
    int k;
    v = int'(op);
    if (rt) begin
      k = int'(amt) % 6;
      if (dir) v = ((v >> k) | (v << (6 - k))) & 63;
      else     v = ((v << k) | (v >> (6 - k))) & 63;
    end else begin
      if (dir) v = v >> int'(amt);
      else     v = (v << int'(amt)) & 63;
    end
    return v[5:0];
  endfunction

  // Issue a request (DUT must be ready) and follow it to its DONE cycle.
  // Inputs are scrambled after the accept edge to show they are not re-sampled.
  task automatic run_op(input logic d, input logic [5:0] op, input logic [2:0] n,
                        input logic rt, input logic [5:0] exp);
    start = 1'b1; to_right = d; operand = op; shamt = n; rot = rt;
    tick();
    start = 1'b0; to_right = ~d; operand = ~op; shamt = ~n; rot = ~rt;
    for (int k = 0; k < int'(n); k++) begin
      chk("busy", int'(busy), 1);
      chk("ready_busy", int'(ready), 0);
      chk("remaining", int'(remaining), int'(n) - k);
      chk("done_early", int'(done), 0);
      if (k == 0) chk("valid_cleared", int'(result_valid), 0);
      tick();
    end
    chk("done_pulse", int'(done), 1);
    chk("result", int'(result), int'(exp));
    chk("valid_done", int'(result_valid), 1);
    chk("busy_done", int'(busy), 0);
    chk("ready_done", int'(ready), 1);
    chk("remaining_done", int'(remaining), 0);
  endtask

  vec_t vecs[10];

  initial begin
    int   saw_done;
    vec_t v;

    n_checks = 0;
    n_pass   = 0;

    vecs[0] = '{1'b0, 6'b000101, 3'd3, 1'b0, 6'b101000};
    vecs[1] = '{1'b1, 6'b110110, 3'd7, 1'b0, 6'b000000};
    vecs[2] = '{1'b1, 6'b101010, 3'd0, 1'b0, 6'b101010};
    vecs[3] = '{1'b0, 6'b000001, 3'd1, 1'b0, 6'b000010};
    vecs[4] = '{1'b1, 6'b100000, 3'd5, 1'b0, 6'b000001};
    vecs[5] = '{1'b0, 6'b111111, 3'd6, 1'b0, 6'b000000};
    vecs[6] = '{1'b1, 6'b101101, 3'd2, 1'b0, 6'b001011};
    vecs[7] = '{1'b0, 6'b010011, 3'd4, 1'b0, 6'b110000};
`ifdef SHIFT_ROTATE_EN
    vecs[8] = '{1'b1, 6'b000001, 3'd2, 1'b1, 6'b010000};
    vecs[9] = '{1'b0, 6'b100000, 3'd7, 1'b1, 6'b000001};
`else
    vecs[8] = '{1'b1, 6'b111111, 3'd6, 1'b0, 6'b000000};
    vecs[9] = '{1'b0, 6'b100001, 3'd7, 1'b0, 6'b000000};
`endif

    // Reset and idle
    reset = 1'b1; start = 1'b0; to_right = 1'b0; operand = '0; shamt = '0; rot = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst_ready", int'(ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_valid", int'(result_valid), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_remaining", int'(remaining), 0);

    // Directed table
    for (int i = 0; i < 10; i++) begin
      v = vecs[i];
      run_op(v.dir, v.op, v.amt, v.rt, v.exp);
      tick();
      chk("idle_no_done", int'(done), 0);
      chk("idle_hold_result", int'(result), int'(v.exp));
      chk("idle_hold_valid", int'(result_valid), 1);
    end

    // Start during 4th busy cycle of right-by-7 is ignored
    start = 1'b1; to_right = 1'b1; operand = 6'b110110; shamt = 3'd7; rot = 1'b0;
    tick();
    start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      chk("ign_busy", int'(busy), 1);
      chk("ign_remaining", int'(remaining), 7 - k);
      if (k == 3) begin
        start = 1'b1; to_right = 1'b0; operand = 6'b111111; shamt = 3'd1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    chk("ign_done", int'(done), 1);
    chk("ign_result", int'(result), 0);
    tick();
    chk("ign_idle", int'(done), 0);

    // Shift by 0, then back-to-back accept in DONE
    start = 1'b1; to_right = 1'b1; operand = 6'b101010; shamt = 3'd0;
    tick();
    chk("b2b_done0", int'(done), 1);
    chk("b2b_result0", int'(result), 6'b101010);
    start = 1'b1; to_right = 1'b0; operand = 6'b000001; shamt = 3'd1;
    tick();
    start = 1'b0;
    chk("b2b_busy", int'(busy), 1);
    chk("b2b_no_done", int'(done), 0);
    chk("b2b_valid_clr", int'(result_valid), 0);
    chk("b2b_remaining", int'(remaining), 1);
    tick();
    chk("b2b_done1", int'(done), 1);
    chk("b2b_result1", int'(result), 6'b000010);
    chk("b2b_valid1", int'(result_valid), 1);
    tick();

    // Reset in 2nd busy cycle of a 5-step shift aborts without done
    start = 1'b1; to_right = 1'b0; operand = 6'b000011; shamt = 3'd5;
    tick();
    start = 1'b0;
    tick();
    chk("abort_busy2", int'(busy), 1);
    reset = 1'b1;
    start = 1'b1; // reset must win over start on the same edge
    tick();
    reset = 1'b0; start = 1'b0;
    chk("abort_ready", int'(ready), 1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_valid", int'(result_valid), 0);
    chk("abort_result", int'(result), 0);
    chk("abort_remaining", int'(remaining), 0);
    saw_done = 0;
    for (int k = 0; k < 8; k++) begin
      if (done) saw_done = 1;
      tick();
    end
    chk("abort_never_done", saw_done, 0);

    // Randomized requests against the reference
    for (int i = 0; i < 40; i++) begin
      logic       d;
      logic [5:0] op;
      logic [2:0] n;
      logic       rt;
      d  = 1'($urandom_range(0, 1));
      op = 6'($urandom_range(0, 63));
      n  = 3'($urandom_range(0, 7));
`ifdef SHIFT_ROTATE_EN
      rt = 1'($urandom_range(0, 1));
`else
      rt = 1'b0;
`endif
      run_op(d, op, n, rt, model(d, op, n, rt));
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) tick();
    end
    tick();
    chk("final_idle_ready", int'(ready), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
